// File: rtl/pixel_stream_tx_pkg.sv
// Shared video raster parameters, RGB888 field layout and the transmit FSM state type.
package pixel_stream_tx_pkg;

    localparam int unsigned H_ACTIVE_DEF = 1280;
    localparam int unsigned V_ACTIVE_DEF = 720;
    localparam int unsigned X_W_DEF      = 11;
    localparam int unsigned Y_W_DEF      = 10;
    localparam int unsigned DATA_W_DEF   = 24;

    // RGB888 pixel packing {R,G,B}, shared with the colour-detect blocks.
    localparam int unsigned CH_W  = 8;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/pixel_stream_tx_raster_counter.sv
// Raster x/y position counter; clear and advance together step from the origin.
module pixel_raster_counter
    import pixel_stream_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned X_W      = X_W_DEF,
    parameter int unsigned Y_W      = Y_W_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last_in_line,
    output logic           o_last_in_frame
);

    localparam logic [X_W-1:0] LAST_X = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(V_ACTIVE - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] w_base_x;
    logic [Y_W-1:0] w_base_y;
    logic [X_W-1:0] w_next_x;
    logic [Y_W-1:0] w_next_y;

    always_comb begin
        w_base_x = i_clear ? '0 : r_x;
        w_base_y = i_clear ? '0 : r_y;
        w_next_x = w_base_x;
        w_next_y = w_base_y;
        if (i_advance) begin
            if (w_base_x == LAST_X) begin
                w_next_x = '0;
                w_next_y = (w_base_y == LAST_Y) ? '0 : w_base_y + Y_W'(1);
            end else begin
                w_next_x = w_base_x + X_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_next_x;
            r_y <= w_next_y;
        end
    end

    assign o_x             = r_x;
    assign o_y             = r_y;
    assign o_last_in_line  = (r_x == LAST_X);
    assign o_last_in_frame = (r_x == LAST_X) && (r_y == LAST_Y);

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster pixel transmitter: accepts RGB beats with SOF/EOL, tags them with X/Y, checks framing.
module pixel_stream_tx
    import pixel_stream_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned X_W      = X_W_DEF,
    parameter int unsigned Y_W      = Y_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    input  logic              S_SOF,
    input  logic              S_EOL,
    output logic              S_READY,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_OUT_VALID,
    output logic [X_W-1:0]    X_VALUE,
    output logic [Y_W-1:0]    Y_VALUE,
    output logic              FRAME_DONE,
    output logic              SOF_ERR,
    output logic              EOL_ERR,
    output logic [31:0]       FRAME_COUNT
);

    localparam bit ORIGIN_LAST_LINE  = (H_ACTIVE == 1);
    localparam bit ORIGIN_LAST_FRAME = (H_ACTIVE == 1) && (V_ACTIVE == 1);

    tx_state_t r_state;
    tx_state_t w_state_next;

    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_frame_done;
    logic              r_sof_err;
    logic              r_eol_err;
    logic [31:0]       r_frame_count;

    logic           w_accept;
    logic           w_emit;
    logic           w_origin;
    logic           w_clear;
    logic           w_advance;
    logic           w_sof_err;
    logic           w_eol_err;
    logic           w_frame_done;
    logic           w_last_line;
    logic           w_last_frame;
    logic           w_at_origin;
    logic [X_W-1:0] w_cnt_x;
    logic [Y_W-1:0] w_cnt_y;
    logic           w_cnt_last_line;
    logic           w_cnt_last_frame;

    pixel_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_raster_counter (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_clear         (w_clear),
        .i_advance       (w_advance),
        .o_x             (w_cnt_x),
        .o_y             (w_cnt_y),
        .o_last_in_line  (w_cnt_last_line),
        .o_last_in_frame (w_cnt_last_frame)
    );

    assign w_accept    = S_VALID && r_ready;
    assign w_at_origin = (w_cnt_x == '0) && (w_cnt_y == '0);

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        w_emit       = 1'b0;
        w_origin     = 1'b0;
        w_sof_err    = 1'b0;
        w_eol_err    = 1'b0;
        w_frame_done = 1'b0;
        w_last_line  = 1'b0;
        w_last_frame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear      = 1'b1;
                w_state_next = ST_WAIT_SOF;
            end
            ST_WAIT_SOF, ST_ACTIVE: begin
                // An SOF beat is always placed at the origin, so its line/frame flags are static.
                w_origin     = S_SOF;
                w_emit       = w_accept && (S_SOF || (r_state == ST_ACTIVE));
                w_sof_err    = w_accept && S_SOF && (r_state == ST_ACTIVE) && !w_at_origin;
                w_last_line  = S_SOF ? ORIGIN_LAST_LINE  : w_cnt_last_line;
                w_last_frame = S_SOF ? ORIGIN_LAST_FRAME : w_cnt_last_frame;
                if (w_emit) begin
                    if (w_last_line != S_EOL) begin
                        w_eol_err    = 1'b1;
                        w_clear      = 1'b1;
                        w_state_next = ST_WAIT_SOF;
                    end else if (w_last_frame) begin
                        w_frame_done = 1'b1;
                        w_clear      = 1'b1;
                        w_state_next = ST_WAIT_SOF;
                    end else begin
                        w_clear      = S_SOF;
                        w_advance    = 1'b1;
                        w_state_next = ST_ACTIVE;
                    end
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_clear      = 1'b1;
            w_advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_done  <= 1'b0;
            r_sof_err     <= 1'b0;
            r_eol_err     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_valid      <= w_emit;
            r_x          <= (w_emit && !w_origin) ? w_cnt_x : '0;
            r_y          <= (w_emit && !w_origin) ? w_cnt_y : '0;
            r_frame_done <= w_frame_done;
            r_sof_err    <= w_sof_err;
            r_eol_err    <= w_eol_err;
            if (w_emit) begin
                r_data <= S_DATA;
            end
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
        end
    end

    assign S_READY        = r_ready;
    assign DATA_OUT       = r_data;
    assign DATA_OUT_VALID = r_valid;
    assign X_VALUE        = r_x;
    assign Y_VALUE        = r_y;
    assign FRAME_DONE     = r_frame_done;
    assign SOF_ERR        = r_sof_err;
    assign EOL_ERR        = r_eol_err;
    assign FRAME_COUNT    = r_frame_count;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx on a reduced 16x8 raster.
module tb_pixel_stream_tx;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [DW-1:0] S_DATA;
    logic          S_VALID;
    logic          S_SOF;
    logic          S_EOL;
    logic          S_READY;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_OUT_VALID;
    logic [XW-1:0] X_VALUE;
    logic [YW-1:0] Y_VALUE;
    logic          FRAME_DONE;
    logic          SOF_ERR;
    logic          EOL_ERR;
    logic [31:0]   FRAME_COUNT;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_stream_tx #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .X_W      (XW),
        .Y_W      (YW),
        .DATA_W   (DW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .S_DATA         (S_DATA),
        .S_VALID        (S_VALID),
        .S_SOF          (S_SOF),
        .S_EOL          (S_EOL),
        .S_READY        (S_READY),
        .DATA_OUT       (DATA_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .X_VALUE        (X_VALUE),
        .Y_VALUE        (Y_VALUE),
        .FRAME_DONE     (FRAME_DONE),
        .SOF_ERR        (SOF_ERR),
        .EOL_ERR        (EOL_ERR),
        .FRAME_COUNT    (FRAME_COUNT)
    );

    typedef struct {
        logic          en;
        logic          v;
        logic          sof;
        logic          eol;
        logic [DW-1:0] d;
        logic          rdy;
        logic          ov;
        int            ox;
        int            oy;
        logic          se;
        logic          ee;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic en, v, sof, eol, input logic [DW-1:0] d,
                                input logic rdy, ov, input int ox, oy, input logic se, ee);
        vec_t r;
        r.en = en; r.v = v; r.sof = sof; r.eol = eol; r.d = d;
        r.rdy = rdy; r.ov = ov; r.ox = ox; r.oy = oy; r.se = se; r.ee = ee;
        return r;
    endfunction

    function automatic logic [DW-1:0] pix(input int x, input int y);
        return {8'hA5, 8'(y), 8'(x)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input int x, input int y,
                           input logic [DW-1:0] d, input logic fd, input logic se, input logic ee);
        logic [63:0] a;
        logic [63:0] e;
        a = {15'b0, DATA_OUT_VALID, X_VALUE, Y_VALUE, (DATA_OUT_VALID ? DATA_OUT : {DW{1'b0}}),
             FRAME_DONE, SOF_ERR, EOL_ERR};
        e = {15'b0, v, XW'(x), YW'(y), (v ? d : {DW{1'b0}}), fd, se, ee};
        chk(name, a, e);
    endtask

    task automatic drive(input logic en, input logic v, input logic sof, input logic eol,
                         input logic [DW-1:0] d);
        enable = en; S_VALID = v; S_SOF = sof; S_EOL = eol; S_DATA = d;
        @(posedge clk);
        #1;
    endtask

    // Sends raster beats with index first..last, optional random idle gaps before each beat.
    task automatic frame_beats(input int first, input int last, input int gap_pct,
                               input logic [31:0] fc_base);
        for (int i = first; i <= last; i++) begin
            int x;
            int y;
            x = i % H;
            y = i / H;
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
                chk_out("gap_idle", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
            end
            drive(1'b1, 1'b1, (i == 0), (x == H - 1), pix(x, y));
            chk_out("frame_beat", 1'b1, x, y, pix(x, y), (i == H * V - 1), 1'b0, 1'b0);
            if (i == H * V - 1) chk("frame_count_last", FRAME_COUNT, fc_base + 32'd1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0; S_VALID = 1'b0; S_SOF = 1'b0; S_EOL = 1'b0; S_DATA = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {DATA_OUT_VALID, X_VALUE, Y_VALUE, DATA_OUT, FRAME_DONE, SOF_ERR, EOL_ERR, S_READY}, '0);
        chk("reset_frame_count", FRAME_COUNT, 32'd0);
        reset_n = 1'b1;

        tbl[0]  = mk(0, 0, 0, 0, 24'h000011, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 24'h000011, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 24'h000022, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 0, 24'h000033, 1, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 24'h000044, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 24'h000055, 1, 1, 1, 0, 0, 0);
        tbl[6]  = mk(1, 1, 1, 0, 24'h000066, 1, 1, 0, 0, 1, 0);
        tbl[7]  = mk(1, 1, 0, 0, 24'h000077, 1, 1, 1, 0, 0, 0);
        tbl[8]  = mk(1, 1, 0, 1, 24'h000088, 1, 1, 2, 0, 0, 1);
        tbl[9]  = mk(1, 1, 0, 0, 24'h000099, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 1, 1, 24'h0000AA, 1, 1, 0, 0, 0, 1);
        tbl[11] = mk(1, 1, 1, 0, 24'h0000BB, 1, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 24'h0000CC, 1, 1, 1, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 24'h0000DD, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 1, 1, 0, 24'h0000EE, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 1, 1, 0, 24'h0000FF, 1, 1, 0, 0, 0, 0);

        for (int k = 0; k < 16; k++) begin
            enable = tbl[k].en; S_VALID = tbl[k].v; S_SOF = tbl[k].sof;
            S_EOL = tbl[k].eol; S_DATA = tbl[k].d;
            chk($sformatf("tbl%0d_ready", k), S_READY, tbl[k].rdy);
            @(posedge clk);
            #1;
            chk_out($sformatf("tbl%0d_out", k), tbl[k].ov, tbl[k].ox, tbl[k].oy, tbl[k].d,
                    1'b0, tbl[k].se, tbl[k].ee);
        end
        chk("tbl_frame_count", FRAME_COUNT, 32'd0);

        // Clean frame with S_VALID held high.
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("ready_wait_sof", S_READY, 1'b1);
        frame_beats(0, H * V - 1, 0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk_out("after_frame_idle", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
        chk("frame_count_1", FRAME_COUNT, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, pix(3, 3));
        chk_out("after_frame_nonsof_drop", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);

        // Frame with ~30% idle cycles.
        frame_beats(0, H * V - 1, 30, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("frame_count_2", FRAME_COUNT, 32'd2);

        // Mid-frame start: non-SOF beats must be dropped.
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 50; k++) begin
            drive(1'b1, 1'b1, 1'b0, ((k % H) == H - 1), pix(k % H, 2));
            chk_out("midframe_drop", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
        end

        // Early EOL at (5,3).
        frame_beats(0, 3 * H + 4, 0, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b1, pix(5, 3));
        chk_out("early_eol", 1'b1, 5, 3, pix(5, 3), 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, pix(6, 3));
        chk_out("after_eol_drop", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);

        // SOF mid-frame at (10,6).
        frame_beats(0, 6 * H + 9, 0, 32'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b0, pix(10, 6));
        chk_out("sof_err_beat", 1'b1, 0, 0, pix(10, 6), 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, pix(1, 0));
        chk_out("after_sof_err", 1'b1, 1, 0, pix(1, 0), 1'b0, 1'b0, 1'b0);

        // enable dropped with the beat at (8,5).
        frame_beats(2, 5 * H + 7, 0, 32'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, pix(8, 5));
        chk_out("disable_beat_emitted", 1'b1, 8, 5, pix(8, 5), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            enable = 1'b0; S_VALID = 1'b1; S_SOF = 1'b1; S_EOL = 1'b0; S_DATA = pix(k, 9);
            chk("disabled_ready", S_READY, 1'b0);
            @(posedge clk);
            #1;
            chk_out("disabled_out", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
        end
        enable = 1'b1; S_VALID = 1'b1; S_SOF = 1'b1; S_EOL = 1'b0; S_DATA = pix(0, 0);
        chk("reenable_ready", S_READY, 1'b0);
        @(posedge clk);
        #1;
        chk_out("reenable_idle_out", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, pix(9, 5));
        chk_out("reenable_nonsof_drop", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
        frame_beats(0, 0, 0, 32'd2);
        chk("frame_count_unchanged", FRAME_COUNT, 32'd2);

        // Asynchronous reset mid-frame.
        frame_beats(1, 4, 0, 32'd2);
        enable = 1'b1; S_VALID = 1'b1; S_SOF = 1'b0; S_EOL = 1'b0; S_DATA = pix(5, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {DATA_OUT_VALID, X_VALUE, Y_VALUE, DATA_OUT, FRAME_DONE, SOF_ERR, EOL_ERR, S_READY}, '0);
        chk("async_reset_frame_count", FRAME_COUNT, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, pix(6, 0));
        chk_out("post_reset_nonsof_drop", 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
        frame_beats(0, 1, 0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
